// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: captures each rx_done rising edge with its parity flag
// and presents the characters first-word-fall-through on a valid/ready stream.
module uart_rx_fifo #(
  parameter int unsigned DATABITS  = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DROP_PERR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATABITS-1:0]      rx_data,
  input  logic                     rx_done,
  input  logic                     parity_error,
  output logic [DATABITS-1:0]      m_data,
  output logic                     m_perr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     perr_seen,
  input  logic                     clear_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATABITS + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          rx_done_q;
  logic          overflow_q;
  logic          perr_seen_q;

  logic rise;
  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic is_full;

  // Request decode: one push per rx_done rising edge, optionally masked on parity error
  always_comb begin
    rise     = rx_done & ~rx_done_q;
    push_req = rise & ~((DROP_PERR != 0) & parity_error);
    is_full  = (count_q == CW'(DEPTH));
    pop      = (count_q != CW'(0)) & m_ready;
    push     = push_req & (~is_full | pop);
    drop     = push_req & is_full & ~pop;
  end

  // Storage is deliberately not reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= {parity_error, rx_data};
    end
  end

  // Pointers, occupancy and edge-detect history
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as clear_err wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      perr_seen_q <= 1'b0;
    end else begin
      if (drop)              overflow_q <= 1'b1;
      else if (clear_err)    overflow_q <= 1'b0;
      if (rise && parity_error) perr_seen_q <= 1'b1;
      else if (clear_err)       perr_seen_q <= 1'b0;
    end
  end

  assign m_data    = mem[rd_ptr][DATABITS-1:0];
  assign m_perr    = mem[rd_ptr][DATABITS];
  assign m_valid   = (count_q != CW'(0));
  assign count     = count_q;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign perr_seen = perr_seen_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of uart_rx. It captures each received character on the rising edge of rx_done, stores the character with its parity-error flag in a circular FIFO, and presents the characters to the system through a valid/ready stream. It also reports occupancy, overflow and parity status, so software or the consumer logic never loses characters to rx_data being overwritten.

Parameters:
DATABITS, 8, character width; must match the uart_rx instance.
DEPTH, 16, number of FIFO entries; power of two, minimum 2.
DROP_PERR, 0, 1 = discard characters that arrive with parity_error set; 0 = store them with a flag.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-low reset.
rx_data  input  DATABITS  character from uart_rx.
rx_done  input  1  character-complete indication from uart_rx; may be held high for more than one cycle.
parity_error  input  1  parity flag for the current rx_data; valid while rx_done is high.
m_data  output  DATABITS  head-of-FIFO character.
m_perr  output  1  parity-error flag of the head entry.
m_valid  output  1  FIFO non-empty; m_data and m_perr are valid.
m_ready  input  1  consumer accepts the head entry when m_valid & m_ready.
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
overflow  output  1  sticky: a character was lost because the FIFO was full.
perr_seen  output  1  sticky: a character arrived with parity_error set.
clear_err  input  1  single-cycle request to clear overflow and perr_seen.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - read and write pointers = 0; count = 0.
  - m_valid = 0, full = 0, overflow = 0, perr_seen = 0.
  - rx_done history register = 0.
  - Memory contents are not reset. m_data and m_perr are don't-care while m_valid = 0.
  - A reset in mid-stream empties the FIFO. No partial state survives.
- Edge detect: rx_done_q registers rx_done every cycle. rise = rx_done & ~rx_done_q. A held rx_done produces exactly one push.
- Push request: push_req = rise, masked to 0 when DROP_PERR = 1 and parity_error = 1.
- Pop: pop = m_valid & m_ready.
- Write: on push_req, the clk edge writes {parity_error, rx_data} at the write pointer, provided the FIFO is not full or a pop happens in the same cycle. The write pointer then increments modulo DEPTH.
- Read: m_data and m_perr are driven combinationally from the entry at the read pointer (first-word fall-through). On pop, the read pointer increments modulo DEPTH.
- Occupancy: count += accepted push, −= pop; a simultaneous push and pop leaves count unchanged.
  - m_valid = (count != 0).
  - full = (count == DEPTH).
  - Pointers wrap naturally at DEPTH−1 → 0.
- Latency: when rise occurs into an empty FIFO, m_valid is high in the following cycle, with m_data equal to that character.
- Full:
  - push_req while full with no pop: character dropped, overflow set, count stays DEPTH.
  - push_req while full with a pop in the same cycle: character accepted, count stays DEPTH.
- Empty: m_ready is ignored while m_valid = 0. The pointers never move.
- Sticky flags:
  - perr_seen is set by any rise with parity_error = 1, including characters dropped under DROP_PERR = 1 or due to overflow.
  - clear_err clears overflow and perr_seen at the next edge.
  - If a set event and clear_err occur in the same cycle, the set wins and the flag stays 1.
- m_valid / m_data stability: once asserted, m_valid stays high and m_data stays stable until the entry is popped. Pushes never disturb the head entry.

Test Plan:
1. Single character: after reset, drive rx_data=0x41, parity_error=0, and hold rx_done high for 3 cycles → exactly one push; m_valid=1 with m_data=0x41 one cycle after rx_done first goes high; count=1.
2. Fill and drain: push 16 characters 0x00..0x0F with m_ready=0 → full=1, count=16. Then hold m_ready=1 → 16 pops in order 0x00..0x0F; m_valid drops after the last pop; pointers have wrapped back to 0.
3. Overflow: with the FIFO full and m_ready=0, push 0xAA → overflow=1, count=16, 0xAA never appears at m_data. Pulse clear_err → overflow=0.
4. Full with simultaneous push and pop: FIFO full and m_ready=1 in the cycle a rise of 0x55 occurs → count stays 16, overflow stays 0, and 0x55 emerges as the 16th character after the current head.
5. Parity handling: DROP_PERR=0, push 0x33 with parity_error=1 → m_perr=1 at the head, perr_seen=1. DROP_PERR=1, same stimulus → count unchanged, perr_seen=1. Assert clear_err in the same cycle as a new parity-error rise → perr_seen stays 1.
6. Reset mid-operation: with count=5, assert reset low for 1 cycle → count=0, m_valid=0, overflow=0, perr_seen=0. The next push appears as the head with the correct data.
